// File: rtl/des_pkg.sv
`default_nettype none
// ============================================================================
// Module      : des_pkg
// Description : Shared DES definitions: permutation and S-box tables, the
//               decryption shift schedule, FSM state encoding and permutation
//               helper functions. Vectors use [N-1:0] storage with DES bit 1
//               at the MSB, so DES bit n of an N-bit word sits at index N-n.
// Revision    : 1.0 - initial release
// ============================================================================
package des_pkg;

    localparam int c_rounds = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } des_state_t;

    localparam int c_ip [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

    localparam int c_fp [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

    localparam int c_pc1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

    localparam int c_pc2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    localparam int c_e [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

    localparam int c_p [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

    // Each S-box is 64 nibbles, row-major (row*16 + col), entry 0 in the MSBs.
    localparam logic [255:0] c_sbox [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

    // Right-rotation per round, indexed by the 4-bit round counter. Round 16
    // wraps the counter to 0, so entry 0 holds the round-16 amount.
    localparam logic [1:0] c_shift_dec [16] = '{
        2'd1, 2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd2, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2};

    function automatic logic [63:0] des_ip(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-c_ip[i]];
        return y;
    endfunction

    function automatic logic [63:0] des_fp(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-c_fp[i]];
        return y;
    endfunction

    function automatic logic [55:0] des_pc1(input logic [63:0] x);
        logic [55:0] y;
        y = '0;
        for (int i = 0; i < 56; i++) y[55-i] = x[64-c_pc1[i]];
        return y;
    endfunction

    function automatic logic [47:0] des_pc2(input logic [55:0] x);
        logic [47:0] y;
        y = '0;
        for (int i = 0; i < 48; i++) y[47-i] = x[56-c_pc2[i]];
        return y;
    endfunction

    function automatic logic [47:0] des_e(input logic [31:0] x);
        logic [47:0] y;
        y = '0;
        for (int i = 0; i < 48; i++) y[47-i] = x[32-c_e[i]];
        return y;
    endfunction

    function automatic logic [31:0] des_p(input logic [31:0] x);
        logic [31:0] y;
        y = '0;
        for (int i = 0; i < 32; i++) y[31-i] = x[32-c_p[i]];
        return y;
    endfunction

    // Row is formed from the outer bits (DES bits 1 and 6), column from 2..5.
    function automatic logic [3:0] des_sbox(input int n, input logic [5:0] b);
        logic [255:0] t;
        t = c_sbox[n] >> (4 * (63 - int'({b[5], b[0], b[4:1]})));
        return t[3:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/des_dec_key_sched.sv
`default_nettype none
// ============================================================================
// Module      : des_dec_key_sched
// Description : Reverse-order DES subkey generator. Holds C/D, rotates them
//               right by 0/1/2 and applies PC-2, so successive steps yield
//               K16, K15, ... K1. The subkey reflects the rotated value before
//               it is written back.
// Ports       : clk, rst        clock, synchronous active-high reset
//               i_load          load C/D from i_cd (PC-1 of the key)
//               i_cd     [55:0] C0D0
//               i_step          commit the rotated C/D
//               i_shift  [1:0]  right-rotation amount for this round
//               o_subkey [47:0] PC-2 of the rotated C/D
// Revision    : 1.0 - initial release
// ============================================================================
module des_dec_key_sched
    import des_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic [55:0] i_cd,
    input  logic        i_step,
    input  logic [1:0]  i_shift,
    output logic [47:0] o_subkey
);

    logic [27:0] r_c;
    logic [27:0] r_d;
    logic [27:0] w_c_rot;
    logic [27:0] w_d_rot;

    always_comb begin
        w_c_rot = r_c;
        w_d_rot = r_d;
        case (i_shift)
            2'd0: begin
                w_c_rot = r_c;
                w_d_rot = r_d;
            end
            2'd1: begin
                w_c_rot = {r_c[0], r_c[27:1]};
                w_d_rot = {r_d[0], r_d[27:1]};
            end
            default: begin
                w_c_rot = {r_c[1:0], r_c[27:2]};
                w_d_rot = {r_d[1:0], r_d[27:2]};
            end
        endcase
    end

    assign o_subkey = des_pc2({w_c_rot, w_d_rot});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_c <= '0;
            r_d <= '0;
        end else if (i_load) begin
            r_c <= i_cd[55:28];
            r_d <= i_cd[27:0];
        end else if (i_step) begin
            r_c <= w_c_rot;
            r_d <= w_d_rot;
        end
    end

endmodule
`default_nettype wire

// File: rtl/des_round_f.sv
`default_nettype none
// ============================================================================
// Module      : des_round_f
// Description : DES round function f(R, K): expansion, key mix, S-boxes and
//               the post-S-box permutation. Purely combinational.
// Ports       : i_r      [31:0] right half
//               i_subkey [47:0] round subkey
//               o_f      [31:0] f output
// Revision    : 1.0 - initial release
// ============================================================================
module des_round_f
    import des_pkg::*;
(
    input  logic [31:0] i_r,
    input  logic [47:0] i_subkey,
    output logic [31:0] o_f
);

    logic [47:0] w_x;
    logic [31:0] w_s;

    assign w_x = des_e(i_r) ^ i_subkey;

    for (genvar g = 0; g < 8; g++) begin : g_sbox
        assign w_s[31-4*g -: 4] = des_sbox(g, w_x[47-6*g -: 6]);
    end

    assign o_f = des_p(w_s);

endmodule
`default_nettype wire

// File: rtl/des_decrypt_iter.sv
`default_nettype none
// ============================================================================
// Module      : des_decrypt_iter
// Description : Iterative single-block DES decryption, one Feistel round per
//               clock. Accept -> 16 rounds -> plaintext held until consumed.
// Ports       : clk, rst           clock, synchronous active-high reset
//               in_valid/in_ready  ciphertext/key handshake
//               ciphertext [63:0]  DES bit 1 at the MSB
//               key        [63:0]  parity bits ignored
//               out_valid/out_ready plaintext handshake
//               plaintext  [63:0]  stable while out_valid is high
//               busy               high while rounds run or result pending
// Revision    : 1.0 - initial release
// ============================================================================
module des_decrypt_iter
    import des_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] ciphertext,
    input  logic [63:0] key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] plaintext,
    output logic        busy
);

    // The 4-bit counter holds rounds 1..15 directly; round 16 reads as 0.
    localparam logic [3:0] c_last_rnd = 4'(c_rounds);

    des_state_t  r_state;
    logic [3:0]  r_rnd;
    logic [31:0] r_l;
    logic [31:0] r_r;
    logic        r_out_valid;
    logic        r_busy;
    logic [63:0] r_plaintext;

    logic [63:0] w_ip;
    logic [47:0] w_subkey;
    logic [31:0] w_f;
    logic [31:0] w_l_next;
    logic [31:0] w_r_next;
    logic        w_accept;

    assign in_ready  = (r_state == ST_IDLE) && !rst;
    assign w_accept  = in_valid && in_ready;
    assign w_ip      = des_ip(ciphertext);
    assign w_l_next  = r_r;
    assign w_r_next  = r_l ^ w_f;

    des_dec_key_sched u_key_sched (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_accept),
        .i_cd     (des_pc1(key)),
        .i_step   (r_state == ST_ROUND),
        .i_shift  (c_shift_dec[r_rnd]),
        .o_subkey (w_subkey)
    );

    des_round_f u_round_f (
        .i_r      (r_r),
        .i_subkey (w_subkey),
        .o_f      (w_f)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_rnd       <= 4'd0;
            r_l         <= '0;
            r_r         <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_plaintext <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_l     <= w_ip[63:32];
                        r_r     <= w_ip[31:0];
                        r_rnd   <= 4'd1;
                        r_busy  <= 1'b1;
                        r_state <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    r_l   <= w_l_next;
                    r_r   <= w_r_next;
                    r_rnd <= r_rnd + 4'd1;
                    if (r_rnd == c_last_rnd) begin
                        // Final swap: the output block is R16 || L16.
                        r_plaintext <= des_fp({w_r_next, w_l_next});
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign plaintext = r_plaintext;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_des_decrypt_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_des_decrypt_iter
// Description : Self-checking bench for des_decrypt_iter. Known-answer and
//               model-generated vectors, backpressure, back-to-back,
//               input-change and mid-operation reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_des_decrypt_iter;
    import des_pkg::*;

    typedef struct {
        logic [63:0] key;
        logic [63:0] ct;
        logic [63:0] pt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [63:0] ciphertext = '0;
    logic [63:0] key = '0;
    logic        in_ready;
    logic        out_valid;
    logic [63:0] plaintext;
    logic        busy;

    int          n_pass = 0;
    int          n_total = 0;
    int          cyc = 0;
    int          last_acc = 0;
    logic [63:0] exp_cur = '0;
    logic [63:0] sb_q[$];
    int          acc_q[$];
    logic        prev_ov = 1'b0;
    logic        hold_pend = 1'b0;
    logic [63:0] hold_pt = '0;
    vec_t        vecs[8];

    des_decrypt_iter dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ciphertext (ciphertext),
        .key        (key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .plaintext  (plaintext),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic fail(input string name);
        n_total++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Independent forward-direction DES (left-rotating key schedule).
    function automatic logic [63:0] model_encrypt(input logic [63:0] k, input logic [63:0] p);
        int          sh [16];
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [47:0] sk, e;
        logic [63:0] x, y;
        logic [31:0] l, r, s, f, t;
        logic [5:0]  b;
        int          idx;
        sh = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
        for (int i = 0; i < 56; i++) cd[55-i] = k[64-c_pc1[i]];
        c = cd[55:28];
        d = cd[27:0];
        for (int i = 0; i < 64; i++) x[63-i] = p[64-c_ip[i]];
        l = x[63:32];
        r = x[31:0];
        s = '0;
        for (int rd = 0; rd < 16; rd++) begin
            for (int j = 0; j < sh[rd]; j++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            for (int i = 0; i < 48; i++) sk[47-i] = cd[56-c_pc2[i]];
            for (int i = 0; i < 48; i++) e[47-i] = r[32-c_e[i]];
            e = e ^ sk;
            for (int g = 0; g < 8; g++) begin
                b   = e[47-6*g -: 6];
                idx = 32 * int'(b[5]) + 16 * int'(b[0]) + int'(b[4:1]);
                s[31-4*g -: 4] = c_sbox[g][255-4*idx -: 4];
            end
            for (int i = 0; i < 32; i++) f[31-i] = s[32-c_p[i]];
            t = r;
            r = l ^ f;
            l = t;
        end
        x = {r, l};
        for (int i = 0; i < 64; i++) y[63-i] = x[64-c_fp[i]];
        return y;
    endfunction

    // Scoreboard monitor: pushes on accept, pops and compares on delivery.
    always @(negedge clk) begin
        cyc++;
        if (hold_pend) begin
            chk("hold_valid", {63'd0, out_valid}, 64'd1);
            chk("hold_data", plaintext, hold_pt);
        end
        hold_pend = out_valid && !out_ready && !rst;
        hold_pt   = plaintext;
        if (out_valid && !prev_ov) begin
            if (acc_q.size() != 0) chk("latency", 64'(cyc - acc_q[0]), 64'd17);
            else fail("unexpected_out_valid");
        end
        if (out_valid && out_ready) begin
            if (sb_q.size() == 0) fail("unexpected_output");
            else begin
                chk("plaintext", plaintext, sb_q.pop_front());
                void'(acc_q.pop_front());
            end
        end
        if (in_valid && in_ready) begin
            sb_q.push_back(exp_cur);
            acc_q.push_back(cyc);
            last_acc = cyc;
        end
        prev_ov = out_valid;
    end

    task automatic wait_accept();
        int n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                break;
            end
            n++;
            if (n > 60) begin
                fail("accept_timeout");
                break;
            end
        end
    endtask

    task automatic send(input vec_t v);
        key        = v.key;
        ciphertext = v.ct;
        exp_cur    = v.pt;
        in_valid   = 1'b1;
        wait_accept();
        in_valid   = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) fail("drain_timeout");
        @(posedge clk);
        #1;
    endtask

    initial begin
        int a1;
        int n;
        vecs[0] = '{64'h133457799BBCDFF1, 64'h85E813540F0AB405, 64'h0123456789ABCDEF};
        vecs[1] = '{64'h0E329232EA6D0D73, 64'h0000000000000000, 64'h8787878787878787};
        vecs[2] = '{64'h0F329232EA6D0D73, 64'h0000000000000000, 64'h8787878787878787};
        vecs[3] = '{64'h0123456789ABCDEF, 64'h3FA40E8A984D4815, 64'h4E6F772069732074};
        for (int i = 4; i < 8; i++) begin
            vecs[i].key = {$urandom, $urandom};
            vecs[i].pt  = {$urandom, $urandom};
            vecs[i].ct  = model_encrypt(vecs[i].key, vecs[i].pt);
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_plaintext", plaintext, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;

        // Vector table
        for (int i = 0; i < 8; i++) begin
            send(vecs[i]);
            wait_drain(40);
        end

        // Backpressure with an ignored offer while the result waits
        out_ready = 1'b0;
        send(vecs[0]);
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) fail("bp_wait_timeout");
        @(posedge clk);
        #1;
        key        = vecs[1].key;
        ciphertext = vecs[1].ct;
        exp_cur    = vecs[1].pt;
        in_valid   = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
            chk("bp_busy", {63'd0, busy}, 64'd1);
            chk("bp_plaintext", plaintext, vecs[0].pt);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_in_ready", {63'd0, in_ready}, 64'd1);
        chk("bp_release_out_valid", {63'd0, out_valid}, 64'd0);
        repeat (20) @(negedge clk);
        chk("bp_no_extra", {63'd0, out_valid}, 64'd0);
        chk("bp_sb_empty", 64'(sb_q.size()), 64'd0);
        @(posedge clk);
        #1;

        // Back-to-back with in_valid held high
        key        = vecs[4].key;
        ciphertext = vecs[4].ct;
        exp_cur    = vecs[4].pt;
        in_valid   = 1'b1;
        wait_accept();
        a1         = last_acc;
        key        = vecs[5].key;
        ciphertext = vecs[5].ct;
        exp_cur    = vecs[5].pt;
        wait_accept();
        in_valid   = 1'b0;
        chk("b2b_period", 64'(last_acc - a1), 64'd18);
        wait_drain(60);

        // Inputs scrambled every cycle after accept
        send(vecs[6]);
        repeat (20) begin
            key        = {$urandom, $urandom};
            ciphertext = {$urandom, $urandom};
            @(posedge clk);
            #1;
        end
        wait_drain(40);

        // Reset during round 7
        send(vecs[7]);
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb_q.delete();
        acc_q.delete();
        @(negedge clk);
        chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_plaintext", plaintext, 64'd0);
        chk("mid_rst_in_ready_after", {63'd0, in_ready}, 64'd1);
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        repeat (20) @(negedge clk);
        chk("mid_rst_no_output", {63'd0, out_valid}, 64'd0);
        @(posedge clk);
        #1;
        send(vecs[0]);
        wait_drain(40);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/des_decrypt_iter.md
# des_decrypt_iter

Iterative single-block DES decryption engine: ciphertext and 64-bit key in, plaintext out, one Feistel round per clock. It is the receive-side counterpart of the encryption datapath. It reuses the existing round-function chain (expansion, S-boxes, post-S-box permutation) and generates subkeys in reverse order (K16 down to K1) on the fly with right rotations. It sits between the ciphertext source and the plaintext consumer, with valid/ready handshakes on both sides.

## Interface
- Parameters: none.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  ciphertext/key pair offered.
- in_ready  output  1  engine idle and able to accept.
- ciphertext  input  [1:64]  DES bit numbering; bit 1 is the MSB.
- key  input  [1:64]  DES key including parity bits 8, 16, …, 64. Parity bits are ignored.
- out_valid  output  1  plaintext available.
- out_ready  input  1  consumer accepts plaintext.
- plaintext  output  [1:64]  decrypted block; held stable while out_valid=1.
- busy  output  1  high in ROUND and DONE.

## Operation
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: register IP(ciphertext) into L/R, and PC-1(key) into C/D.
  - Clear round counter rnd to 1 and go to ROUND.
- ROUND, per cycle, for rnd = 1..16:
  - Subkey = PC-2(C'D'), where C'D' is C/D rotated right by shift_dec[rnd].
  - shift_dec = 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - Round 1 uses the unrotated C0D0, which equals C16D16, giving K16.
  - Update: L<=R; R<=L^f(R,subkey); C/D<=C'D'.
  - rnd increments (4-bit counter); after rnd==16 go to DONE.
- DONE:
  - plaintext = FP({R,L}), i.e. the final swap is applied, registered on the DONE entry edge.
  - out_valid=1.
  - On out_ready go to IDLE.
- Inputs are sampled only on the accepting edge. Later changes to ciphertext or key have no effect on the block in flight.
- in_valid while busy is ignored; no queueing.
- Reset mid-operation (any state):
  - Next cycle: IDLE, out_valid=0, plaintext=0.
  - The in-flight block is discarded; no partial result appears.
- Reset values: state=IDLE, out_valid=0, busy=0, plaintext=64'h0, L/R/C/D=0, rnd=0.
- in_ready = (state==IDLE) && !rst, so it is 0 during reset and 1 on the first cycle after.

## Timing
- Accept edge at cycle T: rounds execute at T+1..T+16; out_valid=1 from T+17.
- Latency from accept to out_valid: 17 cycles.
- DONE→IDLE on the edge where out_ready=1, so in_ready=1 in the following cycle.
- With out_ready tied high: accept, then 18-cycle block period.
- Backpressure: out_valid and plaintext hold indefinitely, with no timeout.
- out_ready while out_valid=0 has no effect.
- Round function path: L/R/C/D regs → rotate → PC-2 → f → XOR → regs, single cycle with no internal pipeline.

## Structure
- Shared package des_pkg holds:
  - IP, FP, PC-1 and PC-2 index tables.
  - The shift_dec schedule.
  - FSM state enum.
  - Round-count constant 16.
- Encryption reuses the same tables.
- f function: instantiate the existing round-function chain unchanged.
- One natural sub-module, des_dec_key_sched:
  - Holds the C/D registers, right rotation by 0/1/2, and PC-2.
  - Has a load strobe and a step strobe, and outputs a 48-bit subkey.
- Top level keeps FSM, counter, L/R, IP/FP and the handshake.

## Test plan
- Key 133457799BBCDFF1, ciphertext 85E813540F0AB405 → plaintext 0123456789ABCDEF, out_valid exactly 17 cycles after accept.
- Key 0E329232EA6D0D73, ciphertext 0000000000000000 → plaintext 8787878787878787. Flipping key parity bit 8 gives the identical result.
- Backpressure: out_ready low 5 cycles after out_valid. Required: plaintext stable, in_ready=0, in_valid ignored. Then out_ready=1 → in_ready=1 next cycle.
- Back-to-back with out_ready=1 and in_valid held high over two blocks: second accept 18 cycles after the first, both results correct.
- Ciphertext and key inputs changed every cycle after accept → result still matches the sampled values.
- rst asserted for one cycle during round 7:
  - Next cycle out_valid=0, plaintext=0, in_ready=1.
  - A fresh decrypt afterwards yields the correct plaintext.
